// File: rtl/sdram2_arb_pkg.sv
// sdram2_arb_pkg: shared types and default parameters for the sdram2 two-port arbiter
package sdram2_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE, S_RFS} arb_state_t;
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [18:0] addr;
    logic [31:0] din;
  } port_req_t;
  localparam int RFS_INTERVAL_D = 1024;
  localparam int RFS_CYCLES_D   = 8;
  localparam int GUARD_CYCLES_D = 2;
  localparam int TIMEOUT_D      = 64;
  // A write with no byte enables means a full-word write.
  function automatic logic [3:0] wr_mask(input logic [3:0] be);
    return be == 4'h0 ? 4'hF : be;
  endfunction
endpackage

// File: rtl/sdram2_arb_if.sv
// sdram2_arb_if: one requester port (level req held until a one-cycle ack)
interface sdram2_arb_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [18:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  modport master(output req, we, be, addr, din, input dout, ack);
  modport slave(input req, we, be, addr, din, output dout, ack);
endinterface

// File: rtl/sdram2_rfs_timer.sv
// sdram2_rfs_timer: periodic refresh request generator with missed-refresh flag
module sdram2_rfs_timer
  import sdram2_arb_pkg::*;
#(
  parameter int RFS_INTERVAL = RFS_INTERVAL_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_ready,
  input  logic rfs_clr,
  output logic rfs_pend,
  output logic dbg_rfs_miss
);
  localparam int W = $clog2(RFS_INTERVAL);
  localparam logic [W-1:0] LAST = W'(RFS_INTERVAL - 1);
  logic [W-1:0] cnt;
  logic         expire;
  assign expire = mem_ready && cnt == LAST;
  // A clear coinciding with expiry consumes the old request, so it is not a miss.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt          <= '0;
      rfs_pend     <= 1'b0;
      dbg_rfs_miss <= 1'b0;
    end else begin
      cnt          <= (!mem_ready || expire) ? '0 : cnt + 1'b1;
      rfs_pend     <= expire | (rfs_pend & ~rfs_clr);
      dbg_rfs_miss <= dbg_rfs_miss | (expire & rfs_pend & ~rfs_clr);
    end
endmodule

// File: rtl/sdram2_arb.sv
// sdram2_arb: round-robin two-port arbiter and refresh scheduler in front of sdram2
module sdram2_arb
  import sdram2_arb_pkg::*;
#(
  parameter int RFS_INTERVAL = RFS_INTERVAL_D,
  parameter int RFS_CYCLES   = RFS_CYCLES_D,
  parameter int GUARD_CYCLES = GUARD_CYCLES_D,
  parameter int TIMEOUT      = TIMEOUT_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ready,
  sdram2_arb_if.slave       a,
  sdram2_arb_if.slave       b,
  output logic [18:0]       mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_wr,
  output logic              mem_rd,
  output logic              mem_rfs,
  input  logic              mem_busy,
  input  logic [31:0]       mem_dout,
  output logic              dbg_rfs_miss,
  output logic              dbg_timeout
);
  localparam logic [7:0] G_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] R_LAST = 8'(RFS_CYCLES - 1);
  arb_state_t  state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        sel, sel_n, last, last_n, we_q, we_n;
  logic [18:0] addr_n;
  logic [31:0] din_n, a_dout_q, a_dout_n, b_dout_q, b_dout_n;
  logic [3:0]  wr_n;
  logic        rd_n, rfs_n, a_ack_q, a_ack_n, b_ack_q, b_ack_n, to_n, rfs_clr, rfs_pend;
  port_req_t   pa, pb, r;
  assign pa     = '{a.we, a.be, a.addr, a.din};
  assign pb     = '{b.we, b.be, b.addr, b.din};
  assign a.dout = a_dout_q;
  assign a.ack  = a_ack_q;
  assign b.dout = b_dout_q;
  assign b.ack  = b_ack_q;
  sdram2_rfs_timer #(.RFS_INTERVAL(RFS_INTERVAL)) u_rfs (
    .clk, .rst_n, .mem_ready, .rfs_clr, .rfs_pend, .dbg_rfs_miss
  );
  // sel/last: 0 = port A, 1 = port B; a tie goes to the port not granted last.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 8'd1;
    sel_n    = sel;
    last_n   = last;
    we_n     = we_q;
    addr_n   = mem_addr;
    din_n    = mem_din;
    wr_n     = 4'h0;
    rd_n     = 1'b0;
    rfs_n    = 1'b0;
    a_ack_n  = 1'b0;
    b_ack_n  = 1'b0;
    a_dout_n = a_dout_q;
    b_dout_n = b_dout_q;
    to_n     = dbg_timeout;
    rfs_clr  = 1'b0;
    r        = pa;
    case (state)
      S_IDLE: begin
        cnt_n = 8'd0;
        if (mem_ready && rfs_pend) begin
          rfs_n   = 1'b1;
          rfs_clr = 1'b1;
          state_n = S_RFS;
        end else if (mem_ready && (a.req || b.req)) begin
          sel_n   = b.req && (!a.req || !last);
          r       = sel_n ? pb : pa;
          addr_n  = r.addr;
          din_n   = r.din;
          we_n    = r.we;
          wr_n    = r.we ? wr_mask(r.be) : 4'h0;
          rd_n    = !r.we;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = 8'd0;
        state_n = S_GUARD;
      end
      S_GUARD: if (cnt == G_LAST) begin
        cnt_n   = 8'd0;
        state_n = S_WAIT;
      end
      // Ack and read data are registered on entry to DONE, so they are visible during it.
      S_WAIT: if (!mem_busy || cnt == T_LAST) begin
        state_n  = S_DONE;
        to_n     = dbg_timeout | mem_busy;
        a_ack_n  = !sel;
        b_ack_n  = sel;
        a_dout_n = (!sel && !we_q) ? mem_dout : a_dout_q;
        b_dout_n = (sel && !we_q) ? mem_dout : b_dout_q;
      end
      S_DONE: begin
        last_n  = sel;
        state_n = S_IDLE;
      end
      S_RFS: if (cnt == R_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sel         <= 1'b0;
      last        <= 1'b1;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_wr      <= '0;
      mem_rd      <= 1'b0;
      mem_rfs     <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_dout_q    <= '0;
      b_dout_q    <= '0;
      dbg_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel         <= sel_n;
      last        <= last_n;
      we_q        <= we_n;
      mem_addr    <= addr_n;
      mem_din     <= din_n;
      mem_wr      <= wr_n;
      mem_rd      <= rd_n;
      mem_rfs     <= rfs_n;
      a_ack_q     <= a_ack_n;
      b_ack_q     <= b_ack_n;
      a_dout_q    <= a_dout_n;
      b_dout_q    <= b_dout_n;
      dbg_timeout <= to_n;
    end
endmodule

// File: tb/tb_sdram2_arb.sv
// tb_sdram2_arb: directed + randomized self-checking bench for sdram2_arb
module tb_sdram2_arb;
  import sdram2_arb_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, mem_busy = 1'b0;
  logic [31:0] mem_dout = '0;
  logic [18:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wr;
  logic        mem_rd, mem_rfs, dbg_rfs_miss, dbg_timeout;
  sdram2_arb_if ia(), ib();
  sdram2_arb dut (
    .clk, .rst_n, .mem_ready, .a(ia), .b(ib), .mem_addr, .mem_din, .mem_wr,
    .mem_rd, .mem_rfs, .mem_busy, .mem_dout, .dbg_rfs_miss, .dbg_timeout
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          rd;
    bit          rfs;
    logic [3:0]  wr;
    logic [18:0] addr;
    logic [31:0] din;
  } ev_t;
  ev_t  log_q[$];
  int   total = 0, bad = 0, rc = 0, strobe_err = 0;
  bit   model_last = 1'b1;
  logic prev_s = 1'b0, cur_s;
  // Refresh timer reference: cycles counted while mem_ready is high.
  always @(posedge clk)
    if (!rst_n) rc <= 0;
    else if (mem_ready) rc <= rc + 1;
  // Log every strobe; flag overlaps and back-to-back strobe cycles.
  always @(negedge clk) begin
    cur_s = mem_rd | mem_rfs | (|mem_wr);
    if (rst_n && cur_s) begin
      if (prev_s || (int'(mem_rd) + int'(mem_rfs) + int'(|mem_wr)) > 1) strobe_err++;
      log_q.push_back('{mem_rd, mem_rfs, mem_wr, mem_addr, mem_din});
    end
    prev_s = rst_n && cur_s;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic drive(input bit p, input bit req, input bit we, input logic [3:0] be,
                       input logic [18:0] addr, input logic [31:0] din);
    if (p) begin ib.req = req; ib.we = we; ib.be = be; ib.addr = addr; ib.din = din; end
    else begin ia.req = req; ia.we = we; ia.be = be; ia.addr = addr; ia.din = din; end
  endtask
  function automatic logic ack_of(input bit p);
    return p ? ib.ack : ia.ack;
  endfunction
  function automatic logic [31:0] dout_of(input bit p);
    return p ? ib.dout : ia.dout;
  endfunction
  // busy_len: cycles of busy after the strobe (0 = never busy, <0 = stuck busy)
  task automatic run_single(input bit p, input bit we, input logic [3:0] be, input logic [18:0] addr,
                            input logic [31:0] din, input logic [31:0] rd, input int busy_len);
    int n0, ack_t, acks, exp_t;
    logic [31:0] old_d, oth_d;
    ev_t ev;
    n0 = log_q.size(); old_d = dout_of(p); oth_d = dout_of(!p); ack_t = -1; acks = 0;
    exp_t = busy_len < 0 ? 4 + TIMEOUT_D : (busy_len + 2 > 5 ? busy_len + 2 : 5);
    mem_dout = rd;
    drive(p, 1'b1, we, be, addr, din);
    for (int i = 0; i < 20 && log_q.size() == n0; i++) step();
    chk("grant", 64'(log_q.size()), 64'(n0 + 1));
    if (log_q.size() != n0 + 1) begin
      drive(p, 1'b0, we, be, addr, din);
      step(100);
      return;
    end
    ev = log_q[n0];
    chk("strobe_rd", ev.rd, !we);
    chk("strobe_wr", ev.wr, we ? (be == 4'h0 ? 4'hF : be) : 4'h0);
    chk("strobe_addr", ev.addr, addr);
    if (we) chk("strobe_din", ev.din, din);
    mem_busy = busy_len != 0;
    for (int t = 2; t <= exp_t + 3; t++) begin
      step();
      if (busy_len > 0 && t == 1 + busy_len) mem_busy = 1'b0;
      if (ack_of(p)) begin
        acks++;
        if (ack_t < 0) begin
          ack_t = t;
          chk("ack_dout", dout_of(p), we ? old_d : rd);
          chk("done_addr", mem_addr, addr);
          drive(p, 1'b0, we, be, addr, din);
        end
      end
    end
    mem_busy = 1'b0;
    chk("ack_lat", 64'(ack_t), 64'(exp_t));
    chk("ack_cnt", 64'(acks), 64'd1);
    chk("other_dout", dout_of(!p), oth_d);
    chk("one_strobe", 64'(log_q.size()), 64'(n0 + 1));
    model_last = p;
  endtask
  initial begin
    int n0, acks, ack_t, rfs_t;
    bit seq[$];
    logic [18:0] aa, ba;
    logic [31:0] ad, bd;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    step(2);
    chk("rst_ctl", {mem_addr, mem_rd, mem_rfs, mem_wr, ia.ack, ib.ack, dbg_rfs_miss, dbg_timeout}, 0);
    chk("rst_data", {mem_din, ia.dout}, 0);
    rst_n = 1'b1;
    step(2);
    // No grants while sdram2 is still initialising.
    drive(0, 1, 0, 4'h0, 19'h00055, 0);
    step(8);
    chk("no_grant_unready", 64'(log_q.size()), 64'd0);
    drive(0, 0, 0, 4'h0, 19'h00055, 0);
    step();
    // First refresh: pending after RFS_INTERVAL counted cycles, issued on the next.
    mem_ready = 1'b1;
    n0 = log_q.size();
    while (!mem_rfs && rc < 1100) step();
    chk("rfs_time", 64'(rc), 64'(RFS_INTERVAL_D + 1));
    step(RFS_CYCLES_D + 1);
    chk("rfs_only", 64'(log_q.size()), 64'(n0 + 1));
    if (log_q.size() > n0) chk("rfs_kind", log_q[n0].rfs, 1'b1);
    chk("rfs_miss0", dbg_rfs_miss, 1'b0);
    step(3);
    run_single(0, 0, 4'h0, 19'h00100, 32'h0, 32'hDEADBEEF, 5);
    step(2);
    run_single(1, 0, 4'h0, 19'h7ABCD, 32'h0, $urandom, 0);
    chk("no_timeout", dbg_timeout, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1 + $urandom_range(0, 3));
      run_single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 19'($urandom), $urandom, $urandom, $urandom_range(0, 6));
    end
    chk("no_timeout2", dbg_timeout, 1'b0);
    // Both ports contending: grants alternate, starting with the port not granted last.
    step(2);
    n0 = log_q.size(); acks = 0;
    aa = 19'($urandom); ba = aa ^ 19'h40001; ad = $urandom; bd = ~ad;
    drive(0, 1, 1, 4'hC, aa, ad);
    drive(1, 1, 1, 4'hC, ba, bd);
    for (int t = 0; t < 300 && acks < 6; t++) begin
      step();
      if (ia.ack) begin acks++; seq.push_back(1'b0); end
      if (ib.ack) begin acks++; seq.push_back(1'b1); end
      if (acks == 6) begin drive(0, 0, 1, 4'hC, aa, ad); drive(1, 0, 1, 4'hC, ba, bd); end
    end
    step(10);
    chk("alt_acks", 64'(acks), 64'd6);
    chk("alt_strobes", 64'(log_q.size()), 64'(n0 + 6));
    for (int i = 0; i < 6 && i < seq.size() && n0 + i < log_q.size(); i++) begin
      bit ep;
      ep = (i % 2 == 0) ? !model_last : model_last;
      chk($sformatf("alt_port%0d", i), seq[i], ep);
      chk($sformatf("alt_addr%0d", i), log_q[n0 + i].addr, ep ? ba : aa);
      chk($sformatf("alt_wr%0d", i), log_q[n0 + i].wr, 4'hC);
    end
    if (seq.size() == 6) model_last = seq[5];
    step(2);
    run_single(0, 0, 4'h0, 19'h01234, 0, $urandom, -1);
    chk("timeout_flag", dbg_timeout, 1'b1);
    step(2);
    run_single(1, 1, 4'h3, 19'h04321, $urandom, 0, 1);
    chk("timeout_sticky", dbg_timeout, 1'b1);
    // Write granted one cycle before refresh expiry: ack first, refresh right after.
    while (rc < 2 * RFS_INTERVAL_D - 2) step();
    n0 = log_q.size(); ack_t = -1; rfs_t = -1;
    drive(0, 1, 1, 4'h5, 19'h02468, 32'h13572468);
    for (int t = 1; t <= 12; t++) begin
      step();
      if (ia.ack && ack_t < 0) begin ack_t = t; drive(0, 0, 1, 4'h5, 19'h02468, 32'h13572468); end
      if (mem_rfs && rfs_t < 0) rfs_t = t;
    end
    chk("pre_ack_lat", 64'(ack_t), 64'd5);
    chk("pre_rfs_after", 64'(rfs_t), 64'(ack_t + 2));
    chk("pre_cnt", 64'(log_q.size()), 64'(n0 + 2));
    if (log_q.size() >= n0 + 2) begin
      chk("pre_first_wr", log_q[n0].wr, 4'h5);
      chk("pre_then_rfs", log_q[n0 + 1].rfs, 1'b1);
    end
    step(RFS_CYCLES_D + 2);
    chk("rfs_miss_end", dbg_rfs_miss, 1'b0);
    // Asynchronous reset in the middle of WAIT.
    drive(0, 1, 0, 4'h0, 19'h0ACE1, 0);
    mem_busy = 1'b1;
    step(12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {mem_addr, mem_rd, mem_rfs, mem_wr, ia.ack, ib.ack, dbg_rfs_miss, dbg_timeout}, 0);
    chk("arst_data", {ia.dout, ib.dout}, 0);
    chk("arst_din", mem_din, 0);
    drive(0, 0, 0, 4'h0, 19'h0ACE1, 0);
    mem_busy = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    n0 = log_q.size(); ack_t = -1;
    drive(0, 1, 0, 4'h0, 19'h11111, 0);
    drive(1, 1, 0, 4'h0, 19'h22222, 0);
    for (int i = 0; i < 20 && log_q.size() == n0; i++) step();
    drive(0, 0, 0, 4'h0, 19'h11111, 0);
    drive(1, 0, 0, 4'h0, 19'h22222, 0);
    chk("tie_grant", 64'(log_q.size()), 64'(n0 + 1));
    if (log_q.size() > n0) chk("tie_to_a", log_q[n0].addr, 19'h11111);
    for (int t = 2; t <= 10; t++) begin
      step();
      if (ia.ack && ack_t < 0) ack_t = t;
    end
    chk("dropped_req_acks", 64'(ack_t), 64'd5);
    chk("no_b_grant", 64'(log_q.size()), 64'(n0 + 1));
    chk("strobe_clean", 64'(strobe_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
